data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single-port data memory (12-bit words, 4096 deep) between the processor cores.
//   Grants at most one access per cycle. Drives the RAM wrEn/addr/dataIn. Returns read data to the winning core one cycle later.
//   Asserts processDone to the RAM once every core reports done and no read is outstanding.
//   Sits between the core array and the data memory instance at top level.
// PARAMETERS
//   NUM_CORES   4                    number of requesting cores (2..16)
//   WIDTH       12                   data word width
//   DEPTH       4096                 memory depth in words
//   ADDR_WIDTH  $clog2(DEPTH)        address width
//   ID_WIDTH    $clog2(NUM_CORES)    core index width
// PORTS
//   clk          in   1                     single clock, all logic posedge
//   rst          in   1                     synchronous, active-high reset
//   core_req     in   NUM_CORES             per-core request; held with its fields until ack
//   core_wrEn    in   NUM_CORES             per-core 1=write, 0=read
//   core_addr    in   NUM_CORES*ADDR_WIDTH  packed addresses, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   core_dataIn  in   NUM_CORES*WIDTH       packed write data, core i at [i*WIDTH +: WIDTH]
//   core_done    in   NUM_CORES             per-core level, high once the core has finished
//   core_ack     out  NUM_CORES             one-hot grant, combinational, same cycle as request
//   core_rdValid out  NUM_CORES             one-hot, read data valid for that core
//   core_dataOut out  WIDTH                 read data, broadcast to all cores
//   ram_wrEn     out  1                     to RAM write enable
//   ram_addr     out  ADDR_WIDTH            to RAM address (RAM registers it)
//   ram_dataIn   out  WIDTH                 to RAM write data
//   ram_dataOut  in   WIDTH                 from RAM, valid the cycle after its address was driven
//   processDone  out  1                     to RAM, end-of-run dump trigger
// BEHAVIOUR
//   Reset: ptr=0, rd_pend=0, state=RUN.
//     Outputs during rst: core_ack=0, core_rdValid=0, ram_wrEn=0, processDone=0.
//   Arbitration: winner is the first requesting core at or after ptr, scanning upward with wrap (i.e. modulo NUM_CORES).
//     On grant: ptr <= winner+1, wrapping to 0 after NUM_CORES-1. No request means ptr unchanged and core_ack=0.
//     Fairness: any core holding req is granted within NUM_CORES cycles.
//   Cycle T grant: core_ack[w]=1. ram_addr=core_addr[w], ram_dataIn=core_dataIn[w], ram_wrEn=core_wrEn[w].
//     With no grant: ram_wrEn=0; ram_addr/ram_dataIn hold last value (don't care).
//   Write: completes at posedge ending T; no response beyond ack.
//   Read: rd_pend<=1 and rd_id<=w at posedge ending T.
//     In T+1: core_rdValid[rd_id]=1 and core_dataOut=ram_dataOut (combinational pass-through).
//   Back-to-back: a new grant in T+1 is allowed while the T read returns (fully pipelined, 1 access/cycle).
//   Ordering: a write granted in T is visible to a read of the same address granted in T+1 or later.
//   Cores must not combinationally derive core_req from core_ack. Fields sampled only in the ack cycle.
//   Done FSM:
//     RUN   -> DRAIN when &core_done.
//     DRAIN -> DONE when rd_pend==0 and no core_req. DRAIN keeps arbitrating.
//     DONE: processDone=1 (registered level), arbitration disabled (core_ack=0). Only rst exits DONE.
//     Any core_done deasserting in DRAIN returns the FSM to RUN.
//   Reset mid-operation: pending read dropped (no rdValid after rst); ptr and FSM restart.
// STRUCTURE
//   Shared package/include (data_mem_pkg.vh): WIDTH, DEPTH, ADDR_WIDTH, NUM_CORES, and FSM encodings
//     ST_RUN=2'd0, ST_DRAIN=2'd1, ST_DONE=2'd2.
//   One sub-module: rr_arbiter (NUM_CORES req, ptr in -> one-hot grant + winner index, purely combinational).
//   Top holds ptr, rd_pend/rd_id registers, done FSM and the RAM muxes.
// TESTING (NUM_CORES=4, bench instantiates the real data memory)
//   1 Single write then read: core1 wr addr 0x010 data 0xABC; next core1 rd 0x010
//     -> ack same cycle each; rdValid=4'b0010, dataOut=0xABC one cycle after read ack.
//   2 All four req reads every cycle from reset
//     -> grants 0,1,2,3,0,... one per cycle; each rdValid one cycle after its ack with its own data.
//   3 Same-address hazard: core0 wr 0xFFF data 0x555; core2 rd 0xFFF requested same cycle
//     -> core0 granted first, core2 next cycle reads 0x555.
//   4 Wrap/fairness: ptr=3, only core3 and core0 req
//     -> core3 then core0; an idle cycle leaves ptr unchanged.
//   5 Reset mid-read: assert rst in cycle after read ack
//     -> no rdValid, ram_wrEn=0, next grant goes to core0.
//   6 Done: all core_done high with one read outstanding
//     -> processDone rises only after that rdValid, stays high, and core_ack stays 0 afterwards.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared sizing defaults and done-FSM encoding for the data memory arbiter.
package data_mem_arbiter_pkg;
  localparam int DM_NUM_CORES  = 4;
  localparam int DM_WIDTH      = 12;
  localparam int DM_DEPTH      = 4096;
  localparam int DM_ADDR_WIDTH = $clog2(DM_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] winner_o,
  output logic           valid_o
);
  always_comb begin
    int idx;
    grant_o  = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        winner_o     = IDW'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of the single-port data RAM between cores; one access per cycle,
// read data returned to the winner one cycle after its ack, processDone once all cores finish.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = DM_NUM_CORES,
  parameter int WIDTH      = DM_WIDTH,
  parameter int DEPTH      = DM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ID_WIDTH   = $clog2(NUM_CORES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            core_req,
  input  logic [NUM_CORES-1:0]            core_wrEn,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*WIDTH-1:0]      core_dataIn,
  input  logic [NUM_CORES-1:0]            core_done,
  output logic [NUM_CORES-1:0]            core_ack,
  output logic [NUM_CORES-1:0]            core_rdValid,
  output logic [WIDTH-1:0]                core_dataOut,
  output logic                            ram_wrEn,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [WIDTH-1:0]                ram_dataIn,
  input  logic [WIDTH-1:0]                ram_dataOut,
  output logic                            processDone
);
  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [ID_WIDTH-1:0]     rd_id_q, rd_id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        din_q, din_d;

  logic [NUM_CORES-1:0]    arb_grant;
  logic [ID_WIDTH-1:0]     arb_winner;
  logic                    arb_vld;
  logic                    arb_en;
  logic                    done_lvl;
  logic                    grant_vld;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WIDTH-1:0]        sel_din;

  rr_arbiter #(.N(NUM_CORES), .IDW(ID_WIDTH)) u_rr (
    .req_i    (core_req),
    .ptr_i    (ptr_q),
    .grant_o  (arb_grant),
    .winner_o (arb_winner),
    .valid_o  (arb_vld)
  );

  // Done FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Done FSM: next state; DRAIN waits for the last read to return and requests to stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (&core_done) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!(&core_done))                  state_d = ST_RUN;
        else if (!rd_pend_q && core_req == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // Done FSM: outputs
  always_comb begin
    done_lvl = (state_q == ST_DONE);
    arb_en   = (state_q != ST_DONE);
  end

  assign grant_vld = arb_vld && arb_en && !rst;
  assign sel_addr  = core_addr[arb_winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_din   = core_dataIn[arb_winner*WIDTH +: WIDTH];

  always_comb begin
    ptr_d     = ptr_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    addr_d    = addr_q;
    din_d     = din_q;
    if (grant_vld) begin
      ptr_d     = (arb_winner == ID_WIDTH'(NUM_CORES - 1)) ? '0 : arb_winner + 1'b1;
      rd_pend_d = !core_wrEn[arb_winner];
      rd_id_d   = arb_winner;
      addr_d    = sel_addr;
      din_d     = sel_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign core_ack     = grant_vld ? arb_grant : '0;
  assign ram_wrEn     = grant_vld && core_wrEn[arb_winner];
  assign ram_addr     = grant_vld ? sel_addr : addr_q;
  assign ram_dataIn   = grant_vld ? sel_din : din_q;
  assign core_rdValid = (rd_pend_q && !rst) ? (NUM_CORES'(1) << rd_id_q) : '0;
  assign core_dataOut = ram_dataOut;
  assign processDone  = done_lvl && !rst;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a registered-address RAM model and a reference arbiter/memory model.
module tb_data_mem_arbiter;
  localparam int N  = 4;
  localparam int W  = 12;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_req, core_wrEn, core_done;
  logic [N*AW-1:0] core_addr;
  logic [N*W-1:0]  core_dataIn;
  logic [N-1:0]    core_ack, core_rdValid;
  logic [W-1:0]    core_dataOut, ram_dataIn, ram_dataOut;
  logic [AW-1:0]   ram_addr, ram_addr_q;
  logic            ram_wrEn, processDone;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_wrEn(core_wrEn),
    .core_addr(core_addr), .core_dataIn(core_dataIn), .core_done(core_done),
    .core_ack(core_ack), .core_rdValid(core_rdValid), .core_dataOut(core_dataOut),
    .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .processDone(processDone)
  );

  // Data memory: address registered, contents default to a known pattern until written
  logic [W-1:0] ram_arr [0:4095];
  bit           written [0:4095];
  function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
    return W'(a * 7 + 3);
  endfunction
  always @(posedge clk) begin
    if (ram_wrEn) begin
      ram_arr[ram_addr] <= ram_dataIn;
      written[ram_addr] <= 1'b1;
    end
    ram_addr_q <= ram_addr;
  end
  assign ram_dataOut = written[ram_addr_q] ? ram_arr[ram_addr_q] : init_val(ram_addr_q);

  // Reference memory contents
  logic [W-1:0] shadow [int];
  function automatic logic [W-1:0] exp_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(AW'(a));
  endfunction

  // Reference arbitration: first requester scanning upward from ptr, modulo N
  function automatic int exp_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_core(input int i, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    core_wrEn[i]           = wr;
    core_addr[i*AW +: AW]  = a;
    core_dataIn[i*W +: W]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; core_req = '0; core_wrEn = '0; core_done = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; core_req = '1; core_wrEn = '1; core_done = '1;
    tick(); settle();
    nchk++; if (core_ack !== 4'b0) begin nerr++; $display("FAIL reset_ack: got %b expected 0000", core_ack); end
    nchk++; if (core_rdValid !== 4'b0) begin nerr++; $display("FAIL reset_rdvalid: got %b expected 0000", core_rdValid); end
    nchk++; if (ram_wrEn !== 1'b0) begin nerr++; $display("FAIL reset_wren: got %b expected 0", ram_wrEn); end
    nchk++; if (processDone !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", processDone); end
    tick();
  endtask

  task automatic test_single_write_read();
    do_reset();
    core_req = 4'b0010; set_core(1, 1'b1, 12'h010, 12'hABC); settle();
    nchk++; if (core_ack !== 4'b0010) begin nerr++; $display("FAIL wr_ack: got %b expected 0010", core_ack); end
    nchk++; if ({ram_wrEn, ram_addr, ram_dataIn} !== {1'b1, 12'h010, 12'hABC})
      begin nerr++; $display("FAIL wr_ram: got %b %h %h expected 1 010 abc", ram_wrEn, ram_addr, ram_dataIn); end
    shadow[12'h010] = 12'hABC;
    tick(); set_core(1, 1'b0, 12'h010, 12'h000); settle();
    nchk++; if (core_ack !== 4'b0010 || ram_wrEn !== 1'b0)
      begin nerr++; $display("FAIL rd_ack: got %b wren %b expected 0010 wren 0", core_ack, ram_wrEn); end
    tick(); core_req = '0; settle();
    nchk++; if (core_rdValid !== 4'b0010) begin nerr++; $display("FAIL rd_valid: got %b expected 0010", core_rdValid); end
    nchk++; if (core_dataOut !== 12'hABC) begin nerr++; $display("FAIL rd_data: got %h expected abc", core_dataOut); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b0, AW'(12'h100 + i), 12'h000);
    core_req = '1;
    for (int k = 0; k < 10; k++) begin
      settle();
      nchk++; if (core_ack !== N'(1 << (k % N)))
        begin nerr++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, core_ack, N'(1 << (k % N))); end
      if (k > 0) begin
        nchk++; if (core_rdValid !== N'(1 << ((k - 1) % N)) || core_dataOut !== exp_rd(12'h100 + (k - 1) % N))
          begin nerr++; $display("FAIL rr_rd[%0d]: got %b %h expected %b %h", k, core_rdValid, core_dataOut,
                                 N'(1 << ((k - 1) % N)), exp_rd(12'h100 + (k - 1) % N)); end
      end
      tick();
    end
    core_req = '0; tick();
  endtask

  task automatic test_hazard();
    do_reset();
    core_req = 4'b0101; set_core(0, 1'b1, 12'hFFF, 12'h555); set_core(2, 1'b0, 12'hFFF, 12'h000); settle();
    nchk++; if (core_ack !== 4'b0001 || ram_wrEn !== 1'b1)
      begin nerr++; $display("FAIL hz_first: got %b wren %b expected 0001 wren 1", core_ack, ram_wrEn); end
    shadow[12'hFFF] = 12'h555;
    tick(); core_req = 4'b0100; settle();
    nchk++; if (core_ack !== 4'b0100) begin nerr++; $display("FAIL hz_second: got %b expected 0100", core_ack); end
    tick(); core_req = '0; settle();
    nchk++; if (core_rdValid !== 4'b0100 || core_dataOut !== 12'h555)
      begin nerr++; $display("FAIL hz_data: got %b %h expected 0100 555", core_rdValid, core_dataOut); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b0, AW'(12'h020 + i), 12'h000);
    core_req = 4'b0100; tick();
    core_req = 4'b1001; settle();
    nchk++; if (core_ack !== 4'b1000) begin nerr++; $display("FAIL wrap_c3: got %b expected 1000", core_ack); end
    tick(); core_req = 4'b0001; settle();
    nchk++; if (core_ack !== 4'b0001) begin nerr++; $display("FAIL wrap_c0: got %b expected 0001", core_ack); end
    tick(); core_req = '0; settle();
    nchk++; if (core_ack !== 4'b0000 || ram_wrEn !== 1'b0)
      begin nerr++; $display("FAIL wrap_idle: got %b wren %b expected 0000 wren 0", core_ack, ram_wrEn); end
    tick(); core_req = 4'b0011; settle();
    nchk++; if (core_ack !== 4'b0010) begin nerr++; $display("FAIL wrap_ptr_hold: got %b expected 0010", core_ack); end
    tick(); core_req = '0; tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    core_req = 4'b0100; set_core(2, 1'b0, 12'h030, 12'h000); tick();
    rst = 1'b1; core_req = '1;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, AW'(12'h040 + i), W'(12'h300 + i));
    settle();
    nchk++; if (core_rdValid !== 4'b0 || ram_wrEn !== 1'b0 || core_ack !== 4'b0)
      begin nerr++; $display("FAIL rstmid_in: got rv %b wren %b ack %b expected 0000 0 0000", core_rdValid, ram_wrEn, core_ack); end
    tick(); rst = 1'b0; settle();
    nchk++; if (core_rdValid !== 4'b0 || core_ack !== 4'b0001)
      begin nerr++; $display("FAIL rstmid_after: got rv %b ack %b expected 0000 0001", core_rdValid, core_ack); end
    shadow[12'h040] = 12'h300;
    tick(); core_req = '0; tick();
  endtask

  task automatic test_done();
    do_reset();
    core_req = 4'b0010; set_core(1, 1'b0, 12'h050, 12'h000); core_done = '1; settle();
    nchk++; if (core_ack !== 4'b0010 || processDone !== 1'b0)
      begin nerr++; $display("FAIL done_grant: got %b pd %b expected 0010 0", core_ack, processDone); end
    tick(); core_req = '0; settle();
    nchk++; if (core_rdValid !== 4'b0010 || processDone !== 1'b0)
      begin nerr++; $display("FAIL done_rdv: got %b pd %b expected 0010 0", core_rdValid, processDone); end
    tick(); tick(); core_req = '1;
    for (int k = 0; k < 4; k++) begin
      settle();
      nchk++; if (processDone !== 1'b1 || core_ack !== 4'b0 || core_rdValid !== 4'b0)
        begin nerr++; $display("FAIL done_hold[%0d]: got pd %b ack %b rv %b expected 1 0000 0000", k, processDone, core_ack, core_rdValid); end
      tick();
    end
    core_req = '0; core_done = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]  p_req;
    logic [N-1:0]  p_wr;
    logic [AW-1:0] p_addr [N];
    logic [W-1:0]  p_dat [N];
    int            m_ptr, w, rv_id;
    bit            rv_vld;
    logic [W-1:0]  rv_dat;
    do_reset();
    p_req = '0; p_wr = '0; m_ptr = 0; rv_vld = 0; rv_id = 0; rv_dat = '0;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_dat[i] = '0; end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) if (!p_req[i] && $urandom_range(0, 1) == 1) begin
        p_req[i] = 1'b1; p_wr[i] = 1'($urandom_range(0, 1));
        p_addr[i] = AW'($urandom_range(0, 7)); p_dat[i] = W'($urandom);
      end
      core_req = p_req;
      for (int i = 0; i < N; i++) set_core(i, p_wr[i], p_addr[i], p_dat[i]);
      w = exp_winner(p_req, m_ptr);
      settle();
      nchk++; if (core_ack !== ((w < 0) ? N'(0) : N'(1 << w)))
        begin nerr++; $display("FAIL rnd_ack[%0d]: got %b winner expected %0d", c, core_ack, w); end
      nchk++; if (core_rdValid !== (rv_vld ? N'(1 << rv_id) : N'(0)) || (rv_vld && core_dataOut !== rv_dat))
        begin nerr++; $display("FAIL rnd_rd[%0d]: got %b %h expected vld %0d id %0d %h", c, core_rdValid, core_dataOut, rv_vld, rv_id, rv_dat); end
      rv_vld = 0;
      if (w >= 0) begin
        nchk++; if (ram_wrEn !== p_wr[w] || ram_addr !== p_addr[w] || (p_wr[w] && ram_dataIn !== p_dat[w]))
          begin nerr++; $display("FAIL rnd_ram[%0d]: got %b %h %h expected %b %h %h", c, ram_wrEn, ram_addr, ram_dataIn, p_wr[w], p_addr[w], p_dat[w]); end
        if (p_wr[w]) shadow[int'(p_addr[w])] = p_dat[w];
        else begin rv_vld = 1; rv_id = w; rv_dat = exp_rd(int'(p_addr[w])); end
        p_req[w] = 1'b0;
        m_ptr = (w + 1) % N;
      end
      tick();
    end
    core_req = '0; tick();
  endtask

  initial begin
    rst = 1'b1; core_req = '0; core_wrEn = '0; core_done = '0; core_addr = '0; core_dataIn = '0;
    #1;
    test_reset();
    test_single_write_read();
    test_round_robin();
    test_hazard();
    test_wrap();
    test_reset_mid_read();
    test_random();
    test_done();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
